// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-master RAM port arbiter.
package ram_arb_pkg;

    typedef logic [0:0] mst_idx_t;

    localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer names the master that wins a tie
// and flips to the other master after every grant.
module rr_arb2
    import ram_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_i,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    mst_idx_t prio_q;

    always_comb begin
        gnt = 2'b00;
        if (!rst_i) begin
            if (req == 2'b11) begin
                gnt = (prio_q == 1'b1) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_i) begin
            prio_q <= 1'b0;
        end else if (gnt[0]) begin
            prio_q <= 1'b1;
        end else if (gnt[1]) begin
            prio_q <= 1'b0;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates fetch (M0) and load/store (M1) onto a single-port RAM, decodes the
// RAM window and routes the 1-cycle read response back to the granted master.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int          RAM_SIZE   = 32768,
    parameter int          ADDR_WIDTH = $clog2(RAM_SIZE),
    parameter int          DATA_WIDTH = 32,
    parameter logic [31:0] BASE_ADDR  = 32'h0010_0000
) (
    input  logic                    clk,
    input  logic                    rst_i,

    input  logic                    m0_req_i,
    output logic                    m0_gnt_o,
    input  logic [31:0]             m0_addr_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_be_i,
    input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
    output logic                    m0_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m0_rdata_o,
    output logic                    m0_err_o,

    input  logic                    m1_req_i,
    output logic                    m1_gnt_o,
    input  logic [31:0]             m1_addr_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_be_i,
    input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
    output logic                    m1_rvalid_o,
    output logic [DATA_WIDTH-1:0]   m1_rdata_o,
    output logic                    m1_err_o,

    output logic                    ram_en_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic                    ram_we_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    // 33-bit end bound so a window at the top of the address map cannot wrap.
    localparam logic [32:0] WIN_END = {1'b0, BASE_ADDR} + 33'(RAM_SIZE);

    bus_req_t   m0_bus;
    bus_req_t   m1_bus;
    bus_req_t   win_bus;
    logic [1:0] gnt;
    mst_idx_t   sel;
    logic       any_gnt;
    logic       in_win;

    logic       rsp_vld_q;
    mst_idx_t   rsp_own_q;
    logic       rsp_err_q;
    logic       rsp_we_q;
    logic       rsp_live;
    logic [DATA_WIDTH-1:0] rsp_data;

    assign m0_bus = '{addr: m0_addr_i, we: m0_we_i, be: m0_be_i, wdata: m0_wdata_i};
    assign m1_bus = '{addr: m1_addr_i, we: m1_we_i, be: m1_be_i, wdata: m1_wdata_i};

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_i (rst_i),
        .req   ({m1_req_i, m0_req_i}),
        .gnt   (gnt)
    );

    assign m0_gnt_o = gnt[0];
    assign m1_gnt_o = gnt[1];
    assign any_gnt  = |gnt;
    assign sel      = gnt[1];
    assign win_bus  = (sel == 1'b1) ? m1_bus : m0_bus;

    assign in_win = (win_bus.addr >= BASE_ADDR) && ({1'b0, win_bus.addr} < WIN_END);

    assign ram_en_o    = any_gnt && in_win;
    assign ram_we_o    = ram_en_o && win_bus.we;
    assign ram_addr_o  = ADDR_WIDTH'(win_bus.addr - BASE_ADDR);
    assign ram_be_o    = win_bus.be;
    assign ram_wdata_o = win_bus.wdata;

    always_ff @(posedge clk) begin
        if (rst_i) begin
            rsp_vld_q <= 1'b0;
            rsp_own_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_we_q  <= 1'b0;
        end else begin
            rsp_vld_q <= any_gnt;
            rsp_own_q <= sel;
            rsp_err_q <= !in_win;
            rsp_we_q  <= win_bus.we;
        end
    end

    // A response still in flight while reset is asserted is suppressed.
    assign rsp_live = rsp_vld_q && !rst_i;

    always_comb begin
        rsp_data = ram_rdata_i;
        if (rsp_err_q) begin
            rsp_data = DATA_WIDTH'(ERR_RDATA);
        end else if (rsp_we_q) begin
            rsp_data = '0;
        end
    end

    assign m0_rvalid_o = rsp_live && (rsp_own_q == 1'b0);
    assign m1_rvalid_o = rsp_live && (rsp_own_q == 1'b1);
    assign m0_err_o    = m0_rvalid_o && rsp_err_q;
    assign m1_err_o    = m1_rvalid_o && rsp_err_q;
    assign m0_rdata_o  = m0_rvalid_o ? rsp_data : '0;
    assign m1_rdata_o  = m1_rvalid_o ? rsp_data : '0;

endmodule
